// File: rtl/uart_pkg.sv
// Shared UART definitions: baud table, divider helper, receiver FSM encoding.
package uart_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam logic [3:0] BAUD_9600   = 4'd0;
    localparam logic [3:0] BAUD_19200  = 4'd1;
    localparam logic [3:0] BAUD_38400  = 4'd2;
    localparam logic [3:0] BAUD_57600  = 4'd3;
    localparam logic [3:0] BAUD_115200 = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clocks per oversample tick; unlisted selections fall back to 9600.
    function automatic logic [15:0] baud_div(input logic [3:0] sel, input int unsigned clk_freq);
        int unsigned rate;
        case (sel)
            BAUD_19200:  rate = 19200;
            BAUD_38400:  rate = 38400;
            BAUD_57600:  rate = 57600;
            BAUD_115200: rate = 115200;
            default:     rate = 9600;
        endcase
        return 16'(clk_freq / (rate * OVERSAMPLE));
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick divider: counts 0..div-1, pulses tick on the last count.
module uart_baud_tick (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [15:0] div,
    output logic        tick
);

    logic [15:0] cnt;

    assign tick = enable && !clear && (cnt == div - 16'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || !enable || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority vote.
// Handshake: rx_done / frame_err are single-cycle strobes with no back-pressure; data holds until the next good frame.
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [3:0] baud_set,
    output logic [7:0] data,
    output logic       rx_done,
    output logic       frame_err,
    output rx_state_e  state_dbg
);

    logic       rx_meta, rx_sync, rx_prev;
    logic       fall;
    rx_state_e  state, state_n;
    logic [3:0] s_cnt, s_n;
    logic [2:0] bit_idx, idx_n;
    logic [7:0] shreg, shreg_n;
    logic [1:0] smp, smp_n;
    logic [7:0] data_n;
    logic       done_n, ferr_n;
    logic [3:0] baud_lat, baud_n;
    logic       div_clear;
    logic       tick;
    logic       maj;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall = rx_prev && !rx_sync;

    uart_baud_tick u_tick (
        .clk    (clk),
        .reset  (reset),
        .clear  (div_clear),
        .enable (state != ST_IDLE),
        .div    (baud_div(baud_lat, CLK_FREQ)),
        .tick   (tick)
    );

    // Third vote is the live synchronized line on the s=9 tick.
    assign maj = (smp[0] & smp[1]) | (smp[0] & rx_sync) | (smp[1] & rx_sync);

    always_comb begin
        state_n   = state;
        s_n       = s_cnt;
        idx_n     = bit_idx;
        shreg_n   = shreg;
        smp_n     = smp;
        data_n    = data;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
        baud_n    = baud_lat;
        div_clear = 1'b0;

        if (tick) begin
            s_n = s_cnt + 4'd1;
            if (s_cnt == 4'd7) smp_n[0] = rx_sync;
            if (s_cnt == 4'd8) smp_n[1] = rx_sync;
        end

        case (state)
            ST_IDLE: begin
                s_n = 4'd0;
                if (fall) begin
                    state_n   = ST_START;
                    div_clear = 1'b1;
                    baud_n    = baud_set;
                end
            end
            ST_START: begin
                if (tick) begin
                    if (s_cnt == 4'd9 && maj) begin
                        state_n = ST_IDLE;
                    end else if (s_cnt == 4'd15) begin
                        state_n = ST_DATA;
                        idx_n   = 3'd0;
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (s_cnt == 4'd9) shreg_n = {maj, shreg[7:1]};
                    if (s_cnt == 4'd15) begin
                        if (bit_idx == 3'd7) state_n = ST_STOP;
                        else                 idx_n   = bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick && s_cnt == 4'd9) begin
                    state_n = ST_IDLE;
                    if (maj) begin
                        data_n = shreg;
                        done_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            s_cnt     <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            smp       <= '0;
            data      <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            baud_lat  <= '0;
        end else begin
            state     <= state_n;
            s_cnt     <= s_n;
            bit_idx   <= idx_n;
            shreg     <= shreg_n;
            smp       <= smp_n;
            data      <= data_n;
            rx_done   <= done_n;
            frame_err <= ferr_n;
            baud_lat  <= baud_n;
        end
    end

    assign state_dbg = state;

endmodule
